riscv_pipe_stage_buf: RTL and testbench
=======================================

# riscv_pipe_stage_buf

Parametrised pipeline stage register for the RV32I core. Carries `NUM_CH` data channels of `DATA_W` bits each between two pipe stages, using a valid/ready handshake with a registered two-entry skid buffer so that `o_ready` has no combinational path from `i_ready`. Supports a synchronous flush for branch/exception squash. It is the stall-capable successor to the fixed 10-field execute-stage register and sits between any two stages (ID/EX, EX/MEM, MEM/WB).

## Interface
- `DATA_W`, default `XLEN` (32): width of one channel.
- `NUM_CH`, default 10: number of channels, 1..32.
- `REGISTER_INIT`, default 0: reset value of every data bit group, replicated per channel.
- `i_clk`, input, 1: clock, rising edge.
- `i_rst`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `i_valid`, input, 1: upstream has data on `i_data`.
- `o_ready`, output, 1: stage can accept; registered.
- `i_data`, input, NUM_CH*DATA_W: channel k at bits [k*DATA_W +: DATA_W].
- `o_valid`, output, 1: `o_data` holds a valid entry.
- `i_ready`, input, 1: downstream accepts.
- `o_data`, output, NUM_CH*DATA_W: same packing as `i_data`.
- `i_flush`, input, 1: discard all held and incoming entries.
- `o_count`, output, 2: occupancy, 0..2.
- `o_stall_cnt`, output, 32: present only with `RISCV_PIPE_STALL_CNT_EN`.

## Operation
- Accept = `i_valid & o_ready`. Deliver = `o_valid & i_ready`.
- Storage: main register (drives `o_data`) and skid register, each with a valid bit.
- States: EMPTY (count 0), FULL (main valid), SKID (main and skid valid).
- EMPTY: accept -> FULL, main <= `i_data`.
- FULL: accept & deliver -> FULL, main <= `i_data`. Accept only -> SKID, skid <= `i_data`. Deliver only -> EMPTY. Neither -> FULL.
- SKID: `o_ready`=0, so no accept. Deliver -> FULL, main <= skid. Otherwise hold.
- `o_ready` = state != SKID; `o_valid` = state != EMPTY; `o_count` = 0/1/2.
- Flush has priority over every transition: next state EMPTY, the same-cycle accept is discarded, and the same-cycle deliver still completes downstream. Data registers hold their contents; only the valid bits clear.
- Data registers load only on the transitions listed above, so `o_data` holds its last value while `o_valid`=0.
- Reset: state EMPTY, `o_valid`=0, `o_ready`=1, `o_count`=0, main/skid data = `REGISTER_INIT` per channel, `o_stall_cnt`=0.

## Timing
- Latency: 1 cycle from accept to `o_valid` with that data.
- Throughput: 1 entry/cycle while `i_ready`=1.
- `o_ready` and `o_valid` are flop outputs. There is no combinational input-to-output path.
- After `i_ready` falls, at most one more entry is accepted (into the skid). `o_ready` is low from the next cycle.
- Flush: `o_valid`=0 and `o_ready`=1 on the cycle after `i_flush`.
- Reset asserted mid-transfer clears everything immediately (asynchronous). The first accept is possible on the first rising edge after `i_rst` deasserts.

## Configuration
- `RISCV_PIPE_STALL_CNT_EN` defined:
  - `o_stall_cnt` exists. It increments by 1 on every cycle with `o_valid=1 & i_ready=0` and saturates at 0xFFFFFFFF.
  - Flush does not clear it; reset clears it to 0.
- `RISCV_PIPE_STALL_CNT_EN` not defined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset value: `REGISTER_INIT`=0xDEAD, NUM_CH=2, assert `i_rst` -> `o_data`=0x0000DEAD_0000DEAD, `o_valid`=0, `o_ready`=1, `o_count`=0.
- Streaming: `i_ready`=1, send 0x1,0x2,0x3 on consecutive cycles -> the same values appear one cycle later, back-to-back, and `o_count` stays 1.
- Skid: hold `i_ready`=0 and send 0xA,0xB,0xC continuously -> 0xA and 0xB are accepted and `o_ready`=0 with `o_count`=2. Release `i_ready` -> outputs are 0xA, 0xB, then 0xC, with no loss or duplication.
- Flush: in SKID state, pulse `i_flush` with `i_valid`=1 carrying 0x55 -> next cycle `o_valid`=0, `o_count`=0, `o_ready`=1, and 0x55 never appears.
- Async reset: assert `i_rst` mid-cycle while FULL -> `o_valid` drops before the next clock edge.
- Stall counter (macro on): `o_valid`=1 with `i_ready`=0 for 7 cycles -> `o_stall_cnt`=7. A flush leaves it at 7; reset returns it to 0.

Source files
------------

// File: rtl/riscv_pipe_stage_buf.sv
// riscv_pipe_stage_buf: valid/ready pipeline stage register with a two-entry
// skid buffer, so o_ready is a flop output with no path from i_ready.
// Carries NUM_CH channels of DATA_W bits. A synchronous i_flush squashes every
// held and incoming entry.
// Optional feature: define RISCV_PIPE_STALL_CNT_EN to add the o_stall_cnt
// output, a saturating count of cycles with o_valid=1 and i_ready=0.
module riscv_pipe_stage_buf #(
    parameter int                DATA_W        = 32,
    parameter int                NUM_CH        = 10,
    parameter logic [DATA_W-1:0] REGISTER_INIT = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    input  logic                     i_flush,
    output logic [1:0]               o_count
`ifdef RISCV_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]              o_stall_cnt
`endif
);

    localparam int W = NUM_CH * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_valid;
    logic           r_ready;
    logic [1:0]     r_count;
    logic [W-1:0]   r_main_data;
    logic [W-1:0]   r_skid_data;

    logic           w_accept;
    logic           w_deliver;
    logic           w_load_main;
    logic           w_load_skid;
    logic           w_main_from_skid;

    assign w_accept  = i_valid & r_ready;
    assign w_deliver = r_valid & i_ready;

    // Next-state and data-load decode; flush overrides every transition and
    // suppresses all data loads so the registers keep their contents.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = FULL;
                    w_load_main = 1'b1;
                end
            end
            FULL: begin
                if (w_accept && w_deliver) begin
                    w_state_nxt = FULL;
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = SKID;
                    w_load_skid = 1'b1;
                end else if (w_deliver) begin
                    w_state_nxt = EMPTY;
                end
            end
            SKID: begin
                if (w_deliver) begin
                    w_state_nxt      = FULL;
                    w_main_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        if (i_flush) begin
            w_state_nxt      = EMPTY;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    // State register plus registered handshake/occupancy outputs decoded from
    // the next state, so o_valid, o_ready and o_count come straight off flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_count <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != EMPTY);
            r_ready <= (w_state_nxt != SKID);
            r_count <= (w_state_nxt == SKID) ? 2'd2 :
                       (w_state_nxt == FULL) ? 2'd1 : 2'd0;
        end
    end

    // Main and skid data registers; they load only on the listed transitions.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main_data <= {NUM_CH{REGISTER_INIT}};
            r_skid_data <= {NUM_CH{REGISTER_INIT}};
        end else begin
            if (w_load_main) begin
                r_main_data <= i_data;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ready = r_ready;
    assign o_count = r_count;
    assign o_data  = r_main_data;

`ifdef RISCV_PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of backpressure cycles; only reset clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !i_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_riscv_pipe_stage_buf.sv
// Bench for riscv_pipe_stage_buf: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_riscv_pipe_stage_buf;

    localparam int DW = 32;
    localparam int NC = 2;
    localparam int W  = DW * NC;
    localparam logic [W-1:0] INIT64 = 64'h0000DEAD_0000DEAD;

    logic         clk;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_data;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic         i_flush;
    logic [1:0]   o_count;
`ifdef RISCV_PIPE_STALL_CNT_EN
    logic [31:0]  o_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO of accepted entries (max 2), last visible head.
    logic [W-1:0] mq[$];
    logic [W-1:0] mhold;
    logic [31:0]  m_stall;

    riscv_pipe_stage_buf #(
        .DATA_W(DW),
        .NUM_CH(NC),
        .REGISTER_INIT(32'hDEAD)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data(i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data(o_data),
        .i_flush(i_flush),
        .o_count(o_count)
`ifdef RISCV_PIPE_STALL_CNT_EN
        ,
        .o_stall_cnt(o_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic         f;
        logic         ev;
        logic         er;
        logic [1:0]   ec;
        logic [W-1:0] ed;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        bit acc;
        bit del;
        bit stall;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        acc   = v && (mq.size() < 2);
        del   = (mq.size() > 0) && r;
        stall = (mq.size() > 0) && !r;
        @(posedge clk);
        #1;
        if (f) begin
            mq.delete();
        end else begin
            if (del) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        if (mq.size() > 0) mhold = mq[0];
        if (stall && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
    endtask

    task automatic model_reset();
        mq.delete();
        mhold   = INIT64;
        m_stall = '0;
    endtask

    task automatic do_reset(input bit check_vals);
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        if (check_vals) begin
            chk("rst_data",  o_data, INIT64);
            chk("rst_valid", W'(o_valid), W'(0));
            chk("rst_ready", W'(o_ready), W'(1));
            chk("rst_count", W'(o_count), W'(0));
`ifdef RISCV_PIPE_STALL_CNT_EN
            chk("rst_stall", W'(o_stall_cnt), W'(0));
`endif
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, W'(o_valid), W'(mq.size() > 0));
        chk({tag, "_ready"}, W'(o_ready), W'(mq.size() < 2));
        chk({tag, "_count"}, W'(o_count), W'(mq.size()));
        chk({tag, "_data"},  o_data, mhold);
`ifdef RISCV_PIPE_STALL_CNT_EN
        chk({tag, "_stall"}, W'(o_stall_cnt), W'(m_stall));
`endif
    endtask

    initial begin
        rst     = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        i_flush = 1'b0;
        mhold   = INIT64;
        m_stall = '0;
        #2;

        // v, d, r, f -> expected valid, ready, count, data (after the edge)
        tbl[0]  = '{1'b1, 64'h1,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h1};
        tbl[1]  = '{1'b1, 64'h2,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h2};
        tbl[2]  = '{1'b1, 64'h3,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h3};
        tbl[3]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'h3};
        tbl[4]  = '{1'b1, 64'hA,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'hA};
        tbl[5]  = '{1'b1, 64'hB,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'hA};
        tbl[6]  = '{1'b1, 64'hC,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'hA};
        tbl[7]  = '{1'b1, 64'hC,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hB};
        tbl[8]  = '{1'b1, 64'hC,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'hC};
        tbl[9]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'hC};
        tbl[10] = '{1'b1, 64'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h11};
        tbl[11] = '{1'b1, 64'h22, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'h11};
        tbl[12] = '{1'b1, 64'h55, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 64'h11};
        tbl[13] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'h11};
        tbl[14] = '{1'b1, 64'h66, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h66};
        tbl[15] = '{1'b1, 64'h77, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 64'h66};

        do_reset(1'b1);

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            chk($sformatf("vec%0d_valid", i), W'(o_valid), W'(tbl[i].ev));
            chk($sformatf("vec%0d_ready", i), W'(o_ready), W'(tbl[i].er));
            chk($sformatf("vec%0d_count", i), W'(o_count), W'(tbl[i].ec));
            chk($sformatf("vec%0d_data", i),  o_data, tbl[i].ed);
        end

        // Asynchronous reset in the middle of a cycle while FULL.
        cycle(1'b1, 64'h99, 1'b0, 1'b0);
        chk("async_pre_valid", W'(o_valid), W'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", W'(o_valid), W'(0));
        chk("async_count", W'(o_count), W'(0));
        chk("async_ready", W'(o_ready), W'(1));
        chk("async_data",  o_data, INIT64);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 64'hAB, 1'b1, 1'b0);
        chk("post_rst_valid", W'(o_valid), W'(1));
        chk("post_rst_data",  o_data, 64'hAB);

`ifdef RISCV_PIPE_STALL_CNT_EN
        // Stall counter: seven backpressure cycles, flush keeps it, reset clears.
        do_reset(1'b0);
        cycle(1'b1, 64'h5, 1'b0, 1'b0);
        repeat (7) cycle(1'b0, 64'h0, 1'b0, 1'b0);
        chk("stall_7", W'(o_stall_cnt), W'(7));
        cycle(1'b0, 64'h0, 1'b1, 1'b1);
        chk("stall_flush", W'(o_stall_cnt), W'(7));
        chk("stall_flush_valid", W'(o_valid), W'(0));
        do_reset(1'b0);
        chk("stall_rst", W'(o_stall_cnt), W'(0));
`endif

        // Randomized traffic against the reference model.
        do_reset(1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic         v;
            logic         r;
            logic         f;
            logic [W-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            r = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 15) == 0);
            d = {$urandom, $urandom};
            cycle(v, d, r, f);
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
